// File: rtl/apb_master_pkg.sv
// Shared types and constants for the APB4 master bridge.
// FSM encodings are plain localparams so older tools and netlist viewers show raw codes.
package apb_master_pkg;

  localparam int DATA_W     = 32;
  localparam int STRB_W     = 4;
  localparam int ADDR_MAX_W = 64;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SETUP  = 2'd1;
  localparam state_t ST_ACCESS = 2'd2;
  localparam state_t ST_RESP   = 2'd3;

  // Address is stored at the widest supported size; the top slices it down to ADDR_W.
  typedef struct packed {
    logic [ADDR_MAX_W-1:0] addr;
    logic                  write;
    logic [DATA_W-1:0]     wdata;
    logic [STRB_W-1:0]     strb;
    logic [2:0]            prot;
  } req_t;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              err;
  } rsp_t;

  // APB4 requires pstrb to be all-zero on read transfers.
  function automatic logic [STRB_W-1:0] apb_strb(input logic write,
                                                 input logic [STRB_W-1:0] strb);
    return write ? strb : '0;
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating ACCESS-phase wait counter; flags the last allowed wait cycle.
// With TIMEOUT=0 the expired flag is tied low and the bridge waits forever.
module apb_wait_timer
  import apb_master_pkg::*;
#(
  parameter int unsigned TIMEOUT = 0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  if (TIMEOUT > 0) begin : g_timeout
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);
    assign expired_o = (cnt_q == LIMIT);
  end else begin : g_no_timeout
    logic unused_cnt;
    assign unused_cnt = ^cnt_q;
    assign expired_o  = 1'b0;
  end

endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB4 requester: valid/ready request in, SETUP/ACCESS on the bus,
// read data and error returned on a valid/ready response channel.
module apb_master_bridge
  import apb_master_pkg::*;
#(
  parameter int unsigned TIMEOUT = 0,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              pclk_i,
  input  logic              preset_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic              req_write_i,
  input  logic [31:0]       req_wdata_i,
  input  logic [3:0]        req_strb_i,
  input  logic [2:0]        req_prot_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic [2:0]        pprot_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [31:0]       pwdata_o,
  output logic [3:0]        pstrb_o,
  input  logic              pready_i,
  input  logic [31:0]       prdata_i,
  input  logic              pslverr_i
);

  state_t state_q, state_d;
  req_t   req_q, req_d;
  rsp_t   rsp_q, rsp_d;
  logic   expired;
  logic   bus_active;
  logic   unused_addr;

  apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk_i     (pclk_i),
    .rst_i     (preset_i),
    .clr_i     ((state_q == ST_IDLE) || (state_q == ST_RESP && rsp_ready_i)),
    .inc_i     ((state_q == ST_ACCESS) && !pready_i),
    .expired_o (expired)
  );

  // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rsp_d   = rsp_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          req_d = '{addr:  ADDR_MAX_W'(req_addr_i),
                    write: req_write_i,
                    wdata: req_wdata_i,
                    strb:  req_strb_i,
                    prot:  req_prot_i};
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        // A late pready wins over the timeout in the same cycle.
        if (pready_i) begin
          rsp_d   = '{rdata: req_q.write ? '0 : prdata_i, err: pslverr_i};
          state_d = ST_RESP;
        end else if (expired) begin
          rsp_d   = '{rdata: '0, err: 1'b1};
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the request latch and response register are reset like any other flop (they are a
  //       few dozen bits, not a RAM), so outputs are well-defined straight out of reset.
  always_ff @(posedge pclk_i or posedge preset_i) begin
    if (preset_i) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      rsp_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
      state_q <= state_d;
      req_q   <= req_d;
      rsp_q   <= rsp_d;
    end
  end

  assign bus_active = (state_q == ST_SETUP) || (state_q == ST_ACCESS);

  assign req_ready_o = (state_q == ST_IDLE);
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_rdata_o = rsp_q.rdata;
  assign rsp_err_o   = rsp_q.err;

  // Bus outputs decode straight from the state flops so reset idles the bus asynchronously.
  assign psel_o    = bus_active;
  assign penable_o = (state_q == ST_ACCESS);
  assign paddr_o   = bus_active ? req_q.addr[ADDR_W-1:0] : '0;
  assign pwrite_o  = bus_active & req_q.write;
  assign pwdata_o  = bus_active ? req_q.wdata : '0;
  assign pstrb_o   = bus_active ? apb_strb(req_q.write, req_q.strb) : '0;
  assign pprot_o   = bus_active ? req_q.prot : '0;

  assign unused_addr = ^req_q.addr;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge (TIMEOUT=4) with a response scoreboard.
module tb_apb_master_bridge;
  import apb_master_pkg::*;

  logic        pclk_i, preset_i;
  logic        req_valid_i, req_ready_o;
  logic [31:0] req_addr_i;
  logic        req_write_i;
  logic [31:0] req_wdata_i;
  logic [3:0]  req_strb_i;
  logic [2:0]  req_prot_i;
  logic        rsp_valid_o, rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic [31:0] paddr_o;
  logic [2:0]  pprot_o;
  logic        psel_o, penable_o, pwrite_o;
  logic [31:0] pwdata_o;
  logic [3:0]  pstrb_o;
  logic        pready_i;
  logic [31:0] prdata_i;
  logic        pslverr_i;

  int n_checks = 0;
  int n_errors = 0;
  rsp_t exp_q[$];

  // Slave model knobs
  logic [31:0] slv_rdata;
  logic        slv_err, slv_hang;
  int          slv_waits;
  int          acc_cnt;

  apb_master_bridge #(.TIMEOUT(4), .ADDR_W(32)) dut (
    .pclk_i(pclk_i), .preset_i(preset_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_write_i(req_write_i),
    .req_wdata_i(req_wdata_i), .req_strb_i(req_strb_i), .req_prot_i(req_prot_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .paddr_o(paddr_o), .pprot_o(pprot_o), .psel_o(psel_o), .penable_o(penable_o),
    .pwrite_o(pwrite_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
    .pready_i(pready_i), .prdata_i(prdata_i), .pslverr_i(pslverr_i)
  );

  initial pclk_i = 1'b0;
  always #5 pclk_i = ~pclk_i;

  always @(posedge pclk_i or posedge preset_i) begin
    if (preset_i) acc_cnt <= 0;
    else if (psel_o && penable_o && !pready_i) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  assign pready_i  = psel_o && penable_o && !slv_hang && (acc_cnt == slv_waits);
  assign prdata_i  = slv_rdata;
  assign pslverr_i = slv_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: pops one expectation per completed response handshake.
  always @(negedge pclk_i) begin
    if (!preset_i && rsp_valid_o && rsp_ready_i) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_rsp: got rdata 0x%0h err %0b with no expectation", rsp_rdata_o, rsp_err_o);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        check("rsp_rdata", {32'd0, rsp_rdata_o}, {32'd0, e.rdata});
        check("rsp_err", {63'd0, rsp_err_o}, {63'd0, e.err});
      end
    end
  end

  task automatic step();
    @(posedge pclk_i);
    #1;
  endtask

  // Drives one request; returns one cycle after acceptance (DUT in SETUP).
  task automatic issue(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [2:0] prot,
                       input logic [31:0] exp_rdata, input logic exp_err, input bit push);
    int n;
    if (push) exp_q.push_back('{rdata: exp_rdata, err: exp_err});
    req_valid_i = 1'b1;
    req_addr_i  = addr;
    req_write_i = wr;
    req_wdata_i = wdata;
    req_strb_i  = strb;
    req_prot_i  = prot;
    n = 0;
    while (!req_ready_o && n < 50) begin
      step();
      n++;
    end
    check("accept_budget", {63'd0, req_ready_o}, 64'd1);
    step();
    req_valid_i = 1'b0;
    req_addr_i  = 32'hFFFF_FFF0;
    req_write_i = ~wr;
    req_wdata_i = 32'hA5A5_A5A5;
    req_strb_i  = 4'h9;
    req_prot_i  = 3'b111;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!req_ready_o && n < 50) begin
      step();
      n++;
    end
    check("idle_budget", {63'd0, req_ready_o}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    preset_i = 1'b1;
    req_valid_i = 1'b0; req_addr_i = '0; req_write_i = 1'b0;
    req_wdata_i = '0; req_strb_i = '0; req_prot_i = '0;
    rsp_ready_i = 1'b1;
    slv_rdata = 32'h1111_2222; slv_err = 1'b0; slv_hang = 1'b0; slv_waits = 0;
    step();
    step();
    // Reset state
    check("rst_req_ready", {63'd0, req_ready_o}, 64'd1);
    check("rst_psel", {63'd0, psel_o}, 64'd0);
    check("rst_penable", {63'd0, penable_o}, 64'd0);
    check("rst_rsp_valid", {63'd0, rsp_valid_o}, 64'd0);
    check("rst_rsp_rdata", {32'd0, rsp_rdata_o}, 64'd0);
    check("rst_paddr", {32'd0, paddr_o}, 64'd0);
    #2 preset_i = 1'b0;
    step();

    // Write, zero wait states: SETUP cycle 1, ACCESS cycle 2, RESP cycle 3
    issue(32'h8, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b000, 32'h0, 1'b0, 1'b1);
    check("wr_setup_psel", {63'd0, psel_o}, 64'd1);
    check("wr_setup_penable", {63'd0, penable_o}, 64'd0);
    check("wr_setup_paddr", {32'd0, paddr_o}, 64'h8);
    check("wr_setup_pwrite", {63'd0, pwrite_o}, 64'd1);
    check("wr_setup_pwdata", {32'd0, pwdata_o}, 64'hDEAD_BEEF);
    check("wr_setup_pstrb", {60'd0, pstrb_o}, 64'hF);
    check("wr_setup_req_ready", {63'd0, req_ready_o}, 64'd0);
    step();
    check("wr_access_penable", {63'd0, penable_o}, 64'd1);
    check("wr_access_paddr", {32'd0, paddr_o}, 64'h8);
    step();
    check("wr_resp_valid", {63'd0, rsp_valid_o}, 64'd1);
    check("wr_resp_psel", {63'd0, psel_o}, 64'd0);
    step();
    check("wr_back_idle", {63'd0, req_ready_o}, 64'd1);

    // Read, 3 wait states: pready on the 4th ACCESS cycle (also the timeout cycle)
    slv_waits = 3; slv_rdata = 32'h1234_5678;
    issue(32'h4, 1'b0, 32'hFFFF_FFFF, 4'hF, 3'b001, 32'h1234_5678, 1'b0, 1'b1);
    check("rd_setup_pstrb", {60'd0, pstrb_o}, 64'h0);
    check("rd_setup_pwrite", {63'd0, pwrite_o}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("rd_access_penable", {63'd0, penable_o}, 64'd1);
      check("rd_access_paddr", {32'd0, paddr_o}, 64'h4);
      check("rd_access_pstrb", {60'd0, pstrb_o}, 64'h0);
      check("rd_access_pprot", {61'd0, pprot_o}, 64'h1);
    end
    step();
    check("rd_resp_valid", {63'd0, rsp_valid_o}, 64'd1);
    step();

    // Slave error with response backpressure, then a queued write accepted only after rsp_ready
    slv_waits = 0; slv_err = 1'b1; slv_rdata = 32'h0BAD_F00D;
    rsp_ready_i = 1'b0;
    issue(32'h100, 1'b0, 32'h0, 4'h0, 3'b000, 32'h0BAD_F00D, 1'b1, 1'b1);
    step();
    step();
    slv_err = 1'b0;
    exp_q.push_back('{rdata: 32'h0, err: 1'b0});
    req_valid_i = 1'b1; req_addr_i = 32'h20; req_write_i = 1'b1;
    req_wdata_i = 32'h55AA_55AA; req_strb_i = 4'h3; req_prot_i = 3'b010;
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", {63'd0, rsp_valid_o}, 64'd1);
      check("bp_rsp_err", {63'd0, rsp_err_o}, 64'd1);
      check("bp_rsp_rdata", {32'd0, rsp_rdata_o}, 64'h0BAD_F00D);
      check("bp_req_ready", {63'd0, req_ready_o}, 64'd0);
      check("bp_psel", {63'd0, psel_o}, 64'd0);
      step();
    end
    rsp_ready_i = 1'b1;
    step();
    check("bp_idle_req_ready", {63'd0, req_ready_o}, 64'd1);
    check("bp_idle_psel", {63'd0, psel_o}, 64'd0);
    step();
    req_valid_i = 1'b0;
    check("bp_next_psel", {63'd0, psel_o}, 64'd1);
    check("bp_next_paddr", {32'd0, paddr_o}, 64'h20);
    check("bp_next_pstrb", {60'd0, pstrb_o}, 64'h3);
    check("bp_next_pprot", {61'd0, pprot_o}, 64'h2);
    check("bp_next_pwdata", {32'd0, pwdata_o}, 64'h55AA_55AA);
    wait_idle();

    // Timeout: pready never rises -> exactly 4 ACCESS cycles then error response
    slv_hang = 1'b1; slv_rdata = 32'hBAD0_BAD0;
    issue(32'h40, 1'b0, 32'h0, 4'h0, 3'b000, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("to_access_psel", {63'd0, psel_o}, 64'd1);
      check("to_access_penable", {63'd0, penable_o}, 64'd1);
    end
    step();
    check("to_abort_psel", {63'd0, psel_o}, 64'd0);
    check("to_abort_rsp_valid", {63'd0, rsp_valid_o}, 64'd1);
    step();

    // Reset during a wait state: bus idles immediately, response discarded
    issue(32'h80, 1'b0, 32'h0, 4'h0, 3'b000, 32'h0, 1'b0, 1'b0);
    step();
    step();
    check("pre_rst_psel", {63'd0, psel_o}, 64'd1);
    preset_i = 1'b1;
    #1;
    check("mid_rst_psel", {63'd0, psel_o}, 64'd0);
    check("mid_rst_penable", {63'd0, penable_o}, 64'd0);
    check("mid_rst_rsp_valid", {63'd0, rsp_valid_o}, 64'd0);
    #2 preset_i = 1'b0;
    slv_hang = 1'b0;
    step();
    check("post_rst_req_ready", {63'd0, req_ready_o}, 64'd1);
    check("post_rst_psel", {63'd0, psel_o}, 64'd0);
    check("post_rst_rsp_valid", {63'd0, rsp_valid_o}, 64'd0);

    // Normal read after reset
    slv_waits = 1; slv_rdata = 32'hCAFE_F00D;
    issue(32'hC, 1'b0, 32'h0, 4'h0, 3'b000, 32'hCAFE_F00D, 1'b0, 1'b1);
    wait_idle();
    step();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
